// File: rtl/generic_sram_byte_en_pkg.sv
// rtl/generic_sram_byte_en_pkg.sv - shared types and helpers for the byte-enable SRAM initiator
package generic_sram_byte_en_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } fill_state_e;

    function automatic int byte_en_bits(input int data_bits);
        return data_bits / 8;
    endfunction

endpackage

// File: rtl/generic_sram_byte_en_if.sv
// rtl/generic_sram_byte_en_if.sv - single-port SRAM interface with per-byte write enables
interface generic_sram_byte_en_if #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 32
);
    localparam int BE_BITS = DATA_BITS / 8;

    logic [ADDR_BITS-1:0] addr;
    logic                 write_en;
    logic [BE_BITS-1:0]   byte_en;
    logic [DATA_BITS-1:0] write_data;
    logic [DATA_BITS-1:0] read_data;

    modport master (
        output addr,
        output write_en,
        output byte_en,
        output write_data,
        input  read_data
    );

    modport slave (
        input  addr,
        input  write_en,
        input  byte_en,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/generic_sram_rsp_fifo.sv
// rtl/generic_sram_rsp_fifo.sv - small synchronous FIFO with occupancy count for read responses
module generic_sram_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                full;
    logic                do_push;
    logic                do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_BITS'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/generic_sram_byte_en_initiator.sv
// rtl/generic_sram_byte_en_initiator.sv - command/response front end driving a 1-cycle-latency SRAM
module generic_sram_byte_en_initiator
    import generic_sram_byte_en_pkg::*;
#(
    parameter int                     MEM_ADDR_BITS = 10,
    parameter int                     MEM_DATA_BITS = 32,
    parameter int                     RSP_DEPTH     = 3,
    parameter bit                     INIT_ON_RESET = 1'b1,
    parameter logic [MEM_DATA_BITS-1:0] INIT_VALUE  = '0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [MEM_ADDR_BITS-1:0]       cmd_addr,
    input  logic [MEM_DATA_BITS/8-1:0]     cmd_byte_en,
    input  logic [MEM_DATA_BITS-1:0]       cmd_wdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [MEM_DATA_BITS-1:0]       rsp_rdata,
    output logic                           o_init_busy,
    generic_sram_byte_en_if.master         m
);
    localparam int BE_BITS  = byte_en_bits(MEM_DATA_BITS);
    localparam int CNT_BITS = $clog2(RSP_DEPTH + 1);

    fill_state_e              state;
    logic [MEM_ADDR_BITS-1:0] ptr;
    logic                     inflight;
    logic [CNT_BITS-1:0]      fifo_count;
    logic [CNT_BITS:0]        credit_used;
    logic                     fifo_empty;
    logic                     accept;
    logic                     accept_wr;

    logic [MEM_ADDR_BITS-1:0] mem_addr;
    logic                     mem_we;
    logic [BE_BITS-1:0]       mem_be;
    logic [MEM_DATA_BITS-1:0] mem_wdata;

    // An in-flight read already owns a FIFO slot, so it counts against the credit.
    assign credit_used = {1'b0, fifo_count} + (CNT_BITS + 1)'(inflight);
    assign cmd_ready   = !i_rst && (state == ST_RUN)
                         && (credit_used < (CNT_BITS + 1)'(RSP_DEPTH));
    assign accept      = cmd_valid && cmd_ready;
    assign accept_wr   = accept && cmd_write;
    assign o_init_busy = (state == ST_INIT);

    always_comb begin
        mem_addr  = cmd_addr;
        mem_we    = accept_wr;
        mem_be    = accept_wr ? cmd_byte_en : '0;
        mem_wdata = cmd_wdata;
        if (state == ST_INIT) begin
            mem_addr  = ptr;
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_wdata = INIT_VALUE;
        end
    end

    assign m.addr       = mem_addr;
    assign m.write_en   = mem_we && !i_rst;
    assign m.byte_en    = mem_be;
    assign m.write_data = mem_wdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            ptr      <= '0;
            inflight <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    ptr      <= ptr + 1'b1;
                    inflight <= 1'b0;
                    if (ptr == '1) state <= ST_RUN;
                end
                default: begin
                    inflight <= accept && !cmd_write;
                end
            endcase
        end
    end

    generic_sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (MEM_DATA_BITS)
    ) u_rsp_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (inflight),
        .push_data (m.read_data),
        .pop       (rsp_valid && rsp_ready),
        .pop_data  (rsp_rdata),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
endmodule

// File: tb/tb_generic_sram_byte_en_initiator.sv
// tb/tb_generic_sram_byte_en_initiator.sv - directed vector bench for the SRAM initiator
module tb_generic_sram_byte_en_initiator;
    localparam logic [31:0] FILL = 32'hA5A5A5A5;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [3:0]  cmd_byte_en;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        o_init_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    generic_sram_byte_en_if #(.ADDR_BITS(4), .DATA_BITS(32)) sram ();

    generic_sram_byte_en_initiator #(
        .MEM_ADDR_BITS (4),
        .MEM_DATA_BITS (32),
        .RSP_DEPTH     (3),
        .INIT_ON_RESET (1'b1),
        .INIT_VALUE    (FILL)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_byte_en (cmd_byte_en),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .o_init_busy (o_init_busy),
        .m           (sram.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // SRAM responder: registered read, byte-lane write
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (sram.write_en) mem[sram.addr] <= merge(mem[sram.addr], sram.write_data, sram.byte_en);
        sram.read_data <= mem[sram.addr];
    end

    // Fill observer: counts fill writes and flags any out of sequence
    int         init_wr;
    int         init_bad;
    logic [3:0] init_addr;
    always @(posedge clk) begin
        if (rst) begin
            init_wr   = 0;
            init_bad  = 0;
            init_addr = 4'd0;
        end else if (sram.write_en && o_init_busy) begin
            if (sram.addr !== init_addr || sram.byte_en !== 4'hF || sram.write_data !== FILL)
                init_bad++;
            init_addr = init_addr + 4'd1;
            init_wr++;
        end
    end

    logic [31:0] exp_mem [16];

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic issue(input bit wr, input logic [3:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
        int w;
        w = 0;
        cmd_write = wr; cmd_addr = a; cmd_byte_en = be; cmd_wdata = wd; cmd_valid = 1'b1;
        while (!cmd_ready && w < 20) begin step(); w++; end
        check("issue_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        if (wr) exp_mem[a] = merge(exp_mem[a], wd, be);
    endtask

    task automatic read_expect(input logic [3:0] a, input logic [31:0] exp, input string tag);
        int lat;
        issue(1'b0, a, 4'h0, 32'h0);
        lat = 1;
        while (!rsp_valid && lat < 8) begin step(); lat++; end
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_rdata"}, rsp_rdata, exp);
        step();
    endtask

    task automatic fill_check(input string tag);
        int cyc;
        int stale;
        cyc = 0;
        stale = 0;
        while (o_init_busy && cyc < 40) begin
            if (rsp_valid) stale++;
            if (cyc == 8) check({tag, "_cmd_ready_mid"}, 32'(cmd_ready), 32'd0);
            step();
            cyc++;
        end
        check({tag, "_busy_cycles"}, 32'(cyc), 32'd16);
        check({tag, "_writes"}, 32'(init_wr), 32'd16);
        check({tag, "_bad_writes"}, 32'(init_bad), 32'd0);
        check({tag, "_stale_rsp"}, 32'(stale), 32'd0);
        check({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 16; i++) exp_mem[i] = FILL;
    endtask

    task automatic burst_read(input int n, input int base, input string tag);
        int nr;
        fork
            begin
                nr = 0;
                for (int i = 0; i < n; i++) begin
                    cmd_write = 1'b0; cmd_addr = 4'(base + i); cmd_valid = 1'b1;
                    if (!cmd_ready) nr++;
                    step();
                end
                cmd_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                while (!rsp_valid && w < 6) begin step(); w++; end
                check({tag, "_first_latency"}, 32'(w), 32'd2);
                for (int i = 0; i < n; i++) begin
                    check($sformatf("%s_valid%0d", tag, i), 32'(rsp_valid), 32'd1);
                    check($sformatf("%s_rdata%0d", tag, i), rsp_rdata, exp_mem[4'(base + i)]);
                    step();
                end
            end
        join
        check({tag, "_ready_drops"}, 32'(nr), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] q [$];
        int acc;

        vecs[0] = '{1'b1, 4'd3,  4'hF,    32'h11223344, 32'h0};
        vecs[1] = '{1'b1, 4'd3,  4'b0100, 32'hFFFFFFFF, 32'h0};
        vecs[2] = '{1'b0, 4'd3,  4'h0,    32'h0,        32'h11FF3344};
        vecs[3] = '{1'b1, 4'd7,  4'b0011, 32'hDEADBEEF, 32'h0};
        vecs[4] = '{1'b0, 4'd7,  4'h0,    32'h0,        32'hA5A5BEEF};
        vecs[5] = '{1'b0, 4'd0,  4'h0,    32'h0,        32'hA5A5A5A5};
        vecs[6] = '{1'b1, 4'd15, 4'b1000, 32'h12345678, 32'h0};
        vecs[7] = '{1'b0, 4'd15, 4'h0,    32'h0,        32'h12A5A5A5};
        vecs[8] = '{1'b1, 4'd0,  4'b0000, 32'hCAFEF00D, 32'h0};
        vecs[9] = '{1'b0, 4'd0,  4'h0,    32'h0,        32'hA5A5A5A5};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'd0;
        cmd_byte_en = 4'h0; cmd_wdata = 32'h0; rsp_ready = 1'b1;
        repeat (3) step();
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_init_busy", 32'(o_init_busy), 32'd1);
        check("reset_write_en", 32'(sram.write_en), 32'd0);
        rst = 1'b0;
        fill_check("fill");

        burst_read(16, 0, "fill_readback");

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                issue(1'b1, vecs[i].addr, vecs[i].be, vecs[i].wdata);
                check($sformatf("vec%0d_no_rsp_t1", i), 32'(rsp_valid), 32'd0);
                step();
                check($sformatf("vec%0d_no_rsp_t2", i), 32'(rsp_valid), 32'd0);
            end else begin
                read_expect(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
            end
        end

        for (int i = 8; i < 16; i++) issue(1'b1, 4'(i), 4'hF, 32'hC0DE0000 | 32'(i * 17));
        step();
        burst_read(8, 8, "b2b");

        // Back-pressure: only RSP_DEPTH reads may be accepted
        rsp_ready = 1'b0; acc = 0; cmd_write = 1'b0; cmd_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cmd_addr = 4'(8 + acc);
            if (cmd_ready) acc++;
            step();
        end
        cmd_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd3);
        check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_hold_valid%0d", c), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_hold_rdata%0d", c), rsp_rdata, exp_mem[8]);
            step();
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_drain_valid%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_drain_rdata%0d", i), rsp_rdata, exp_mem[8 + i]);
            step();
        end
        check("bp_empty", 32'(rsp_valid), 32'd0);
        check("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);

        // Interleaved write/read/write/read to one address
        fork
            begin
                cmd_addr = 4'd5; cmd_byte_en = 4'hF; cmd_valid = 1'b1;
                cmd_write = 1'b1; cmd_wdata = 32'h0A0A0A0A; step();
                cmd_write = 1'b0; step();
                cmd_write = 1'b1; cmd_wdata = 32'h0B0B0B0B; step();
                cmd_write = 1'b0; step();
                cmd_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    if (rsp_valid) q.push_back(rsp_rdata);
                    step();
                end
            end
        join
        check("il_rsp_count", 32'(q.size()), 32'd2);
        check("il_rsp0", (q.size() > 0) ? q[0] : 32'h0, 32'h0A0A0A0A);
        check("il_rsp1", (q.size() > 1) ? q[1] : 32'h0, 32'h0B0B0B0B);

        // Reset with two responses queued and one read in flight
        rsp_ready = 1'b0; cmd_write = 1'b0; cmd_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin cmd_addr = 4'(i); step(); end
        cmd_valid = 1'b0;
        check("mid_pre_rsp_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_write_en", 32'(sram.write_en), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_init_busy", 32'(o_init_busy), 32'd1);
        step();
        check("mid_rst_write_en_held", 32'(sram.write_en), 32'd0);
        step();
        rst = 1'b0;
        fill_check("refill");
        check("refill_rsp_valid", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b1;
        read_expect(4'd3, FILL, "refill_read3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/generic_sram_byte_en_initiator.md
Name: generic_sram_byte_en_initiator

Overview:
- Initiator (client) end of generic_sram_byte_en_if: drives addr/write_en/byte_en/write_data and samples read_data from any SRAM responder on that interface.
- Converts a valid/ready command stream into SRAM accesses and returns read data on a valid/ready response stream.
- Buffers read data so response back-pressure never loses data from the fixed 1-cycle-latency SRAM.
- Optionally fills the whole memory with a constant after reset; used in front of on-chip RAMs by bus bridges and DMA engines.

Parameters:
MEM_ADDR_BITS, 10, SRAM word-address width
MEM_DATA_BITS, 32, SRAM data width; multiple of 8
RSP_DEPTH, 3, response FIFO entries; minimum 2; 3 needed for 1 read/cycle
INIT_ON_RESET, 1, 1 = fill memory after reset, 0 = go straight to RUN
INIT_VALUE, 0, MEM_DATA_BITS-wide fill word

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  MEM_ADDR_BITS  word address
cmd_byte_en  in  MEM_DATA_BITS/8  write byte lanes
cmd_wdata  in  MEM_DATA_BITS  write data
rsp_valid  out  1  read data valid
rsp_ready  in  1  response consumer ready
rsp_rdata  out  MEM_DATA_BITS  read data
o_init_busy  out  1  fill in progress
m  generic_sram_byte_en_if.master  -  SRAM interface; addr, write_en, byte_en and write_data driven here; read_data sampled

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: state=INIT if INIT_ON_RESET else RUN; init pointer=0; FIFO empty; inflight=0.
- Outputs during reset: cmd_ready=0, rsp_valid=0, o_init_busy=INIT_ON_RESET, m.write_en=0. write_en is gated by !i_rst.
- FSM INIT:
  - each cycle drives addr=ptr, write_en=1, byte_en=all ones, write_data=INIT_VALUE; ptr increments.
  - when ptr is all ones, that write is issued and state moves to RUN on the next edge.
  - exactly 2^MEM_ADDR_BITS cycles. o_init_busy=1 and cmd_ready=0 throughout.
- FSM RUN: o_init_busy=0. Stays in RUN until reset.
- cmd_ready = (state==RUN) && (fifo_count + inflight < RSP_DEPTH). Independent of cmd_valid, cmd_write and rsp_ready.
- Accept cycle T:
  - m.addr=cmd_addr combinationally.
  - write: write_en=1, byte_en=cmd_byte_en, write_data=cmd_wdata. No response is generated.
  - read: write_en=0, byte_en=0; inflight set for cycle T+1.
- Idle cycles: write_en=0, byte_en=0; addr=cmd_addr (don't care).
- Read return:
  - m.read_data sampled in cycle T+1 and pushed into the FIFO at the end of T+1.
  - rsp_valid first seen in T+2. Minimum read latency is 2 cycles from accept to rsp_valid.
- Response FIFO:
  - rsp_valid = !empty; rsp_rdata = head entry; pop on rsp_valid&&rsp_ready.
  - push and pop in the same cycle are legal; count is unchanged.
- Ordering: responses are strictly in read-issue order. A write accepted after a read does not affect that read's data.
- Throughput: with RSP_DEPTH=3 and rsp_ready held 1, one read per cycle is sustained. The credit rule guarantees the FIFO never overflows.
- Back-pressure: rsp_valid and rsp_rdata are held stable while rsp_ready=0.
- Reset mid-operation: FIFO contents and inflight read are discarded; state returns to INIT (if enabled) with ptr=0; partial fill restarts from address 0.

Decomposition:
- generic_sram_byte_en_pkg: state enum (INIT, RUN) and a helper function for byte-enable width (MEM_DATA_BITS/8).
- Sub-module generic_sram_rsp_fifo: parameterised DEPTH/WIDTH synchronous FIFO with count output, async active-high reset; instantiated once for responses.

Test Plan:
- INIT_ON_RESET=1, MEM_ADDR_BITS=4, INIT_VALUE=32'hA5A5A5A5 -> o_init_busy high exactly 16 cycles, 16 writes to addr 0..15 with byte_en=4'hF, then cmd_ready=1; reads of all 16 addresses return A5A5A5A5.
- Write addr 3 data 32'h11223344 byte_en 4'hF, then write addr 3 data 32'hFFFFFFFF byte_en 4'b0100, then read addr 3 -> rsp_rdata=32'h11FF3344, rsp_valid 2 cycles after read accept.
- 8 back-to-back reads with rsp_ready=1 -> cmd_ready stays 1, 8 responses on 8 consecutive cycles, in order.
- Reads issued with rsp_ready=0 -> exactly 3 accepted, then cmd_ready=0; rsp_rdata stable. Raising rsp_ready drains 3 in order and cmd_ready returns to 1.
- Interleaved write A / read A / write A' / read A -> responses A then A'; only reads produce rsp_valid.
- Assert i_rst with 2 responses queued and a read inflight -> rsp_valid=0 immediately; m.write_en=0 while in reset; after release, fill restarts at addr 0 and no stale response appears.
